// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment pattern/code types, named codes and the pattern-to-code decoder
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  typedef logic [4:0] digcode_t;
  localparam digcode_t CODE_SEG_A = 5'd16;
  localparam digcode_t CODE_BLANK = 5'd23;
  localparam digcode_t CODE_H     = 5'd24;
  localparam digcode_t CODE_L     = 5'd25;
  localparam digcode_t CODE_R     = 5'd26;
  localparam digcode_t CODE_LC_L  = 5'd27;
  localparam digcode_t CODE_LC_R  = 5'd28;
  // Returns {unknown, code}; aliased patterns map to the lower code ('1' not 27, 'A' not 26).
  function automatic logic [5:0] seg7_to_code(input seg7_t s);
    case (s)
      7'b1111110: return {1'b0, 5'd0};
      7'b0000110: return {1'b0, 5'd1};
      7'b1101101: return {1'b0, 5'd2};
      7'b1111001: return {1'b0, 5'd3};
      7'b0110011: return {1'b0, 5'd4};
      7'b1011011: return {1'b0, 5'd5};
      7'b1011111: return {1'b0, 5'd6};
      7'b1110000: return {1'b0, 5'd7};
      7'b1111111: return {1'b0, 5'd8};
      7'b1111011: return {1'b0, 5'd9};
      7'b1110111: return {1'b0, 5'd10};
      7'b0011111: return {1'b0, 5'd11};
      7'b1001110: return {1'b0, 5'd12};
      7'b0111101: return {1'b0, 5'd13};
      7'b1001111: return {1'b0, 5'd14};
      7'b1000111: return {1'b0, 5'd15};
      7'b1000000: return {1'b0, CODE_SEG_A};
      7'b0100000: return {1'b0, 5'd17};
      7'b0010000: return {1'b0, 5'd18};
      7'b0001000: return {1'b0, 5'd19};
      7'b0000100: return {1'b0, 5'd20};
      7'b0000010: return {1'b0, 5'd21};
      7'b0000001: return {1'b0, 5'd22};
      7'b0000000: return {1'b0, CODE_BLANK};
      7'b0110111: return {1'b0, CODE_H};
      7'b0001110: return {1'b0, CODE_L};
      7'b0000101: return {1'b0, CODE_LC_R};
      default:    return {1'b1, CODE_BLANK};
    endcase
  endfunction
endpackage

// File: rtl/seg_stable_detect.sv
// seg_stable_detect: registers the display bus and strobes once per stable one-hot window
// Ports: seg_in/dig_sel raw bus in; capture strobe with cap_idx (digit index) and cap_seg (pattern).
module seg_stable_detect
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int IW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  seg7_t                 seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  capture,
  output logic [IW-1:0]         cap_idx,
  output seg7_t                 cap_seg
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  seg7_t s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0] s_sel_q, s_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable;
  // The incoming sample is compared with the one already registered, so the count
  // reflects how long the registered sample has been repeating.
  always_comb begin
    s_seg_d = seg_in;
    s_sel_d = dig_sel;
    stable  = $onehot(dig_sel) && ({seg_in, dig_sel} == {s_seg_q, s_sel_q});
    cnt_d   = !stable ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    capture = stable && (cnt_q == CW'(STABLE_CYCLES - 1));
    cap_seg = s_seg_q;
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (s_sel_q[i]) cap_idx = IW'(i);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s_seg_q <= '0;
      s_sel_q <= '0;
      cnt_q   <= '0;
    end else begin
      s_seg_q <= s_seg_d;
      s_sel_q <= s_sel_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: captures a multiplexed seven-segment bus into decoded digit frames
// Ports: seg_in/dig_sel display bus; frame_codes/frame_unknown/frame_valid with frame_ready
// handshake; capture_pulse strobes once per accepted digit capture.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  seg7_t                   seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [5*NUM_DIGITS-1:0] frame_codes,
  output logic [NUM_DIGITS-1:0]   frame_unknown,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    capture_pulse
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  logic capture;
  logic [IW-1:0] cap_idx;
  seg7_t cap_seg;
  logic [5:0] dec;
  logic [NUM_DIGITS-1:0] cap_mask, seen_q, seen_d, unk_q, unk_d, frame_unknown_q, frame_unknown_d;
  logic [5*NUM_DIGITS-1:0] shadow_q, shadow_d, frame_codes_q, frame_codes_d;
  logic [0:0] state_q, state_d;
  logic capture_pulse_q, capture_pulse_d, hs, load;
  seg_stable_detect #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) u_detect (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .capture(capture), .cap_idx(cap_idx), .cap_seg(cap_seg)
  );
  // A capture coinciding with the handshake keeps its seen bit; the frame load uses
  // the next-state shadow so a completing capture lands in the presented frame.
  always_comb begin
    dec      = seg7_to_code(cap_seg);
    cap_mask = capture ? (NUM_DIGITS'(1) << cap_idx) : '0;
    shadow_d = shadow_q;
    unk_d    = unk_q;
    if (capture) begin
      shadow_d[5*cap_idx +: 5] = dec[4:0];
      unk_d[cap_idx]           = dec[5];
    end
    hs              = (state_q == PRESENT) && frame_ready;
    load            = (state_q == COLLECT) && (&(seen_q | cap_mask));
    seen_d          = (hs ? '0 : seen_q) | cap_mask;
    state_d         = load ? PRESENT : hs ? COLLECT : state_q;
    frame_codes_d   = load ? shadow_d : frame_codes_q;
    frame_unknown_d = load ? unk_d : frame_unknown_q;
    capture_pulse_d = capture;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shadow_q        <= {NUM_DIGITS{CODE_BLANK}};
      unk_q           <= '0;
      seen_q          <= '0;
      state_q         <= COLLECT;
      frame_codes_q   <= '0;
      frame_unknown_q <= '0;
      capture_pulse_q <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      unk_q           <= unk_d;
      seen_q          <= seen_d;
      state_q         <= state_d;
      frame_codes_q   <= frame_codes_d;
      frame_unknown_q <= frame_unknown_d;
      capture_pulse_q <= capture_pulse_d;
    end
  assign frame_codes   = frame_codes_q;
  assign frame_unknown = frame_unknown_q;
  assign frame_valid   = (state_q == PRESENT);
  assign capture_pulse = capture_pulse_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [3:0] dig_sel = '0;
  logic [19:0] frame_codes;
  logic [3:0] frame_unknown;
  logic frame_valid;
  logic frame_ready = 1'b0;
  logic capture_pulse;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses = 0;
  int last_cap = 0;
  int t0 = 0;
  int p0;
  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .frame_codes(frame_codes), .frame_unknown(frame_unknown), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .capture_pulse(capture_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (capture_pulse) begin
      pulses = pulses + 1;
      last_cap = cyc;
    end
  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_in = s;
    dig_sel = d;
    t0 = cyc;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (5) begin
      @(negedge clk);
      seg_in = 7'($urandom);
      dig_sel = 4'($urandom);
      frame_ready = 1'($urandom);
    end
    @(negedge clk);
    n_checks++; if (frame_codes !== 20'd0) begin n_fail++; $display("FAIL reset_codes: got %h expected 0", frame_codes); end
    n_checks++; if (frame_unknown !== 4'd0) begin n_fail++; $display("FAIL reset_unknown: got %b expected 0", frame_unknown); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    n_checks++; if (capture_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", capture_pulse); end
    seg_in = '0; dig_sel = '0; frame_ready = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b expected 0", frame_valid); end
  endtask
  task automatic test_basic_frame;
    p0 = pulses;
    drive(7'b1111110, 4'b0001, 20);
    drive(7'b0000110, 4'b0010, 20);
    drive(7'b1110111, 4'b0100, 20);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", frame_valid); end
    drive(7'b0000000, 4'b1000, 20);
    n_checks++; if (pulses - p0 !== 4) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 4", pulses - p0); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", frame_valid); end
    n_checks++; if (frame_codes !== {5'd23, 5'd10, 5'd1, 5'd0}) begin n_fail++; $display("FAIL basic_codes: got %h expected %h", frame_codes, {5'd23, 5'd10, 5'd1, 5'd0}); end
    n_checks++; if (frame_unknown !== 4'b0000) begin n_fail++; $display("FAIL basic_unknown: got %b expected 0000", frame_unknown); end
  endtask
  task automatic test_stability;
    p0 = pulses;
    drive(7'b0000110, 4'b0010, 15);
    n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL short_hold: got %0d captures expected 0", pulses - p0); end
    drive(7'b1111001, 4'b0010, 40);
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL long_hold: got %0d captures expected 1", pulses - p0); end
    n_checks++; if (last_cap - t0 !== 17) begin n_fail++; $display("FAIL capture_latency: got %0d expected 17", last_cap - t0); end
  endtask
  task automatic test_backpressure;
    p0 = pulses;
    drive(7'b1011011, 4'b0001, 100);
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL recapture: got %0d expected 1", pulses - p0); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL held_valid: got %b expected 1", frame_valid); end
    n_checks++; if (frame_codes !== {5'd23, 5'd10, 5'd1, 5'd0}) begin n_fail++; $display("FAIL held_codes: got %h expected %h", frame_codes, {5'd23, 5'd10, 5'd1, 5'd0}); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_valid: got %b expected 0", frame_valid); end
  endtask
  task automatic test_unknown_frame;
    p0 = pulses;
    drive(7'b0000101, 4'b0010, 20);
    drive(7'b1010101, 4'b0100, 20);
    drive(7'b0100000, 4'b1000, 20);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame2_early_valid: got %b expected 0", frame_valid); end
    drive(7'b1011011, 4'b0001, 20);
    n_checks++; if (pulses - p0 !== 4) begin n_fail++; $display("FAIL frame2_pulses: got %0d expected 4", pulses - p0); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame2_valid: got %b expected 1", frame_valid); end
    n_checks++; if (frame_codes !== {5'd17, 5'd23, 5'd28, 5'd5}) begin n_fail++; $display("FAIL frame2_codes: got %h expected %h", frame_codes, {5'd17, 5'd23, 5'd28, 5'd5}); end
    n_checks++; if (frame_unknown !== 4'b0100) begin n_fail++; $display("FAIL frame2_unknown: got %b expected 0100", frame_unknown); end
  endtask
  task automatic test_not_onehot;
    p0 = pulses;
    drive(7'b1111111, 4'b0011, 50);
    drive(7'b1111111, 4'b0000, 20);
    n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL not_onehot: got %0d captures expected 0", pulses - p0); end
  endtask
  task automatic test_back_to_back;
    drive(7'b1111111, 4'b0100, 16);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    n_checks++; if (capture_pulse !== 1'b1) begin n_fail++; $display("FAIL coincident_pulse: got %b expected 1", capture_pulse); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL coincident_handshake: got %b expected 0", frame_valid); end
    repeat (3) @(negedge clk);
    drive(7'b1111110, 4'b0001, 20);
    drive(7'b0110111, 4'b0010, 20);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame3_early_valid: got %b expected 0", frame_valid); end
    drive(7'b0001110, 4'b1000, 20);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL seen_survives: got %b expected 1", frame_valid); end
    n_checks++; if (frame_codes !== {5'd25, 5'd8, 5'd24, 5'd0}) begin n_fail++; $display("FAIL frame3_codes: got %h expected %h", frame_codes, {5'd25, 5'd8, 5'd24, 5'd0}); end
    n_checks++; if (frame_unknown !== 4'b0000) begin n_fail++; $display("FAIL frame3_unknown: got %b expected 0000", frame_unknown); end
  endtask
  task automatic test_mid_reset;
    reset_n = 1'b0;
    #1;
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", frame_valid); end
    n_checks++; if (frame_codes !== 20'd0) begin n_fail++; $display("FAIL midreset_codes: got %h expected 0", frame_codes); end
  endtask
  initial begin
    test_reset;
    test_basic_frame;
    test_stability;
    test_backpressure;
    test_unknown_frame;
    test_not_onehot;
    test_back_to_back;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
